// File: rtl/plab4_net_terminal_inject.sv
// Injection stage ahead of a router terminal port: tags requests with source id and
// rolling opaque tag, buffers them in a 2-entry FIFO, and caps outstanding messages.
module plab4_net_terminal_inject #(
  parameter int unsigned p_payload_nbits   = 32,
  parameter int unsigned p_opaque_nbits    = 3,
  parameter int unsigned p_srcdest_nbits   = 3,
  parameter int unsigned p_router_id       = 0,
  parameter int unsigned p_num_routers     = 8,
  parameter int unsigned p_max_outstanding = 4,
  localparam int unsigned c_net_msg_nbits  = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits,
  localparam int unsigned c_cnt_nbits      = $clog2(p_max_outstanding+1)
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_val,
  output logic                       req_rdy,
  input  logic [p_srcdest_nbits-1:0] req_dest,
  input  logic [p_payload_nbits-1:0] req_payload,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [c_net_msg_nbits-1:0] out_msg,
  input  logic                       done_val,
  output logic [c_cnt_nbits-1:0]     num_inflight
);

  localparam logic [c_cnt_nbits-1:0]     c_max = c_cnt_nbits'(p_max_outstanding);
  localparam logic [p_srcdest_nbits-1:0] c_src = p_srcdest_nbits'(p_router_id);

  logic [c_net_msg_nbits-1:0] buf_q [2];
  logic                       head_q;
  logic                       tail_q;
  logic [1:0]                 count_q;
  logic [p_opaque_nbits-1:0]  tag_q;
  logic [c_cnt_nbits-1:0]     inflight_q;

  logic buf_full;
  logic buf_empty;
  logic enq;
  logic deq;
  logic done_eff;
  logic [c_net_msg_nbits-1:0] new_msg;

  always_comb begin
    buf_full     = (count_q == 2'd2);
    buf_empty    = (count_q == 2'd0);
    req_rdy      = !reset && !buf_full && (inflight_q < c_max);
    out_val      = !reset && !buf_empty;
    out_msg      = buf_q[head_q];
    num_inflight = inflight_q;
    enq          = req_val && req_rdy;
    deq          = out_val && out_rdy;
    // A completion at zero outstanding is spurious and dropped, even alongside a fire.
    done_eff     = done_val && (inflight_q != '0);
    new_msg      = {req_dest, c_src, tag_q, req_payload};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      if (enq) begin
        tail_q <= ~tail_q;
        tag_q  <= tag_q + 1'b1;
      end
      if (deq)
        head_q <= ~head_q;
      count_q <= count_q + 2'(enq) - 2'(deq);
      if (enq && !done_eff)
        inflight_q <= inflight_q + 1'b1;
      else if (!enq && done_eff)
        inflight_q <= inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq)
      buf_q[tail_q] <= new_msg;
  end

endmodule

// File: tb/tb_plab4_net_terminal_inject.sv
// Randomized scoreboard bench for plab4_net_terminal_inject with directed preambles.
module tb_plab4_net_terminal_inject;

  localparam int P   = 32;
  localparam int O   = 3;
  localparam int S   = 3;
  localparam int ID  = 2;
  localparam int MAX = 4;
  localparam int C   = P + O + 2*S;
  localparam int CW  = $clog2(MAX+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic [S-1:0]  req_dest = '0;
  logic [P-1:0]  req_payload = '0;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [C-1:0]  out_msg;
  logic          done_val = 1'b0;
  logic [CW-1:0] num_inflight;

  plab4_net_terminal_inject #(
    .p_payload_nbits   (P),
    .p_opaque_nbits    (O),
    .p_srcdest_nbits   (S),
    .p_router_id       (ID),
    .p_num_routers     (8),
    .p_max_outstanding (MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_dest     (req_dest),
    .req_payload  (req_payload),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_msg      (out_msg),
    .done_val     (done_val),
    .num_inflight (num_inflight)
  );

  always #5 clk = ~clk;

  logic [C-1:0] sb [$];
  int occ = 0;
  int tag = 0;
  int inflight = 0;
  int npass = 0;
  int ntot = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // One clock of stimulus; the model is advanced from the values seen at the falling edge.
  task automatic cycle(input bit rv, input logic [S-1:0] d, input logic [P-1:0] pl,
                       input bit ordy, input bit dn, input bit rst);
    bit exp_rdy;
    bit fire;
    logic [O-1:0] t;
    @(posedge clk); #1;
    req_val = rv; req_dest = d; req_payload = pl;
    out_rdy = ordy; done_val = dn; reset = rst;
    @(negedge clk);
    occ = sb.size();
    exp_rdy = !rst && (occ < 2) && (inflight < MAX);
    check(req_rdy == exp_rdy, "req_rdy", 64'(req_rdy), 64'(exp_rdy));
    check(int'(num_inflight) == inflight, "num_inflight", 64'(num_inflight), 64'(inflight));
    fire = rv && exp_rdy;
    if (rst) begin
      sb.delete();
      tag = 0;
      inflight = 0;
    end else begin
      if (fire) begin
        t = tag[O-1:0];
        sb.push_back({d, S'(ID), t, pl});
        tag = (tag + 1) % (1 << O);
      end
      inflight = inflight + int'(fire) - int'(dn && inflight > 0);
    end
  endtask

  task automatic idle(input bit ordy, input bit dn);
    cycle(1'b0, '0, '0, ordy, dn, 1'b0);
  endtask

  initial begin : monitor
    logic [C-1:0] exp;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        check(out_val == 1'b0, "out_val_in_reset", 64'(out_val), 64'd0);
      end else begin
        check(out_val == (occ > 0), "out_val", 64'(out_val), 64'(occ > 0));
        if (out_val) begin
          if (sb.size() == 0) begin
            check(1'b0, "out_msg_unexpected", 64'(out_msg), 64'd0);
          end else begin
            exp = sb[0];
            check(out_msg == exp, "out_msg", 64'(out_msg), 64'(exp));
            if (out_rdy) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin : driver
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);

    // single inject, then completion
    cycle(1, 3'd5, 32'hCAFE0001, 1, 0, 0);
    idle(1, 0);
    idle(1, 1);

    // backpressure: three back-to-back requests, then drain in order
    for (int i = 0; i < 3; i++) cycle(1, S'($urandom), $urandom, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    for (int i = 0; i < 3; i++) idle(1, 0);
    idle(1, 1);
    idle(1, 1);

    // spurious completion at zero, then a fire
    idle(1, 1);
    cycle(1, 3'd2, $urandom, 1, 0, 0);
    idle(1, 1);

    // outstanding cap, then fire together with a completion at the cap
    for (int i = 0; i < 4; i++) cycle(1, S'($urandom), $urandom, 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle(1, S'($urandom), $urandom, 1, 0, 0);
    idle(1, 1);
    cycle(1, S'($urandom), $urandom, 1, 1, 0);
    for (int i = 0; i < 4; i++) idle(1, 1);

    // opaque wrap with completion after each delivery
    for (int i = 0; i < 9; i++) begin
      cycle(1, S'($urandom), $urandom, 1, 0, 0);
      idle(1, 0);
      idle(1, 1);
    end

    // reset with two buffered messages and three outstanding
    cycle(1, S'($urandom), $urandom, 1, 0, 0);
    idle(1, 0);
    cycle(1, S'($urandom), $urandom, 0, 0, 0);
    cycle(1, S'($urandom), $urandom, 0, 0, 0);
    cycle(0, '0, '0, 0, 0, 1);
    idle(1, 0);
    cycle(1, 3'd7, $urandom, 1, 0, 0);
    idle(1, 1);

    // randomized traffic with occasional mid-stream resets
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) != 0, S'($urandom), $urandom, ($urandom % 3) != 0,
            ($urandom % 3) == 0, ($urandom % 400) == 0);

    // bounded drain
    for (int i = 0; i < 8; i++) idle(1, 1);
    check(sb.size() == 0, "drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
